// File: rtl/wac_adc_capture.sv
`default_nettype none
// ============================================================================
// wac_adc_capture: dual serial-ADC acquisition, packs 12-bit pairs into BRAM.
// Rev 1.0
// ============================================================================
module wac_adc_capture #(
  parameter int CLK_DIV = 2,
  parameter int QUIET   = 4
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        start,
  input  logic [9:0]  nFrames,
  output logic        busy,
  output logic        done,
  output logic        CSADC1,
  output logic        CSADC2,
  output logic        CLKADC1,
  output logic        CLKADC2,
  input  logic        SDOADC1,
  input  logic        SDOADC2,
  output logic [11:0] busBramAddr,
  output logic [7:0]  busBramOut,
  output logic        ctrlWeBram
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CSLOW = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_QUIET = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // One shared phase counter serves every timed state.
  localparam int CNT_TOP = (2 * CLK_DIV > QUIET) ? ((2 * CLK_DIV > 4) ? 2 * CLK_DIV : 4)
                                                 : ((QUIET > 4) ? QUIET : 4);
  localparam int CW = $clog2(CNT_TOP);

  localparam logic [CW-1:0] C_HALF_M1  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_HALF     = CW'(CLK_DIV);
  localparam logic [CW-1:0] C_PER_M1   = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] C_WR_M1    = CW'(3);
  localparam logic [CW-1:0] C_QUIET_M1 = CW'(QUIET - 1);

  logic [2:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [3:0]    bit_q,    bit_d;
  logic [10:0]   frames_q, frames_d;
  logic [11:0]   addr_q,   addr_d;
  logic [11:0]   ch1_q,    ch1_d;
  logic [11:0]   ch2_q,    ch2_d;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      frames_q <= '0;
      addr_q   <= '0;
      ch1_q    <= '0;
      ch2_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      frames_q <= frames_d;
      addr_q   <= addr_d;
      ch1_q    <= ch1_d;
      ch2_q    <= ch2_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    frames_d = frames_q;
    addr_d   = addr_q;
    ch1_d    = ch1_q;
    ch2_d    = ch2_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          frames_d = (nFrames == 10'd0) ? 11'd1024 : {1'b0, nFrames};
          addr_d   = '0;
          cnt_d    = '0;
          state_d  = S_CSLOW;
        end
      end
      S_CSLOW: begin
        if (cnt_q == C_HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        // Sample on the edge that raises the serial clock; 12-bit regs keep only the last 12 bits.
        if (cnt_q == C_HALF_M1) begin
          ch1_d = {ch1_q[10:0], SDOADC1};
          ch2_d = {ch2_q[10:0], SDOADC2};
        end
        if (cnt_q == C_PER_M1) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd15) state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        addr_d = addr_q + 12'd1;
        if (cnt_q == C_WR_M1) begin
          cnt_d   = '0;
          state_d = S_QUIET;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_QUIET: begin
        if (cnt_q == C_QUIET_M1) begin
          cnt_d    = '0;
          frames_d = frames_q - 11'd1;
          state_d  = (frames_q == 11'd1) ? S_DONE : S_CSLOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic w_cs;
  logic w_sclk;

  always_comb begin
    w_cs       = !((state_q == S_CSLOW) || (state_q == S_SHIFT));
    w_sclk     = !((state_q == S_SHIFT) && (cnt_q < C_HALF));
    busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    done       = (state_q == S_DONE);
    ctrlWeBram = (state_q == S_WRITE);
    busBramOut = 8'h00;
    if (state_q == S_WRITE) begin
      case (cnt_q[1:0])
        2'd0:    busBramOut = ch1_q[7:0];
        2'd1:    busBramOut = {4'b0000, ch1_q[11:8]};
        2'd2:    busBramOut = ch2_q[7:0];
        default: busBramOut = {4'b0000, ch2_q[11:8]};
      endcase
    end
  end

  assign CSADC1      = w_cs;
  assign CSADC2      = w_cs;
  assign CLKADC1     = w_sclk;
  assign CLKADC2     = w_sclk;
  assign busBramAddr = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_wac_adc_capture.sv
`default_nettype none
// ============================================================================
// tb_wac_adc_capture: scoreboard bench for the dual ADC capture engine.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_wac_adc_capture;

  typedef struct packed {
    logic        inst;
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    int          inst;
    int          nf;
    logic [15:0] p1;
    logic [15:0] p2;
    int          flen;
    int          poke;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nRst;
  logic        start_r [2];
  logic [9:0]  nf_r    [2];
  logic        sdo1    [2];
  logic        sdo2    [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic        cs1     [2];
  logic        cs2     [2];
  logic        ck1     [2];
  logic        ck2     [2];
  logic        we_w    [2];
  logic [11:0] addr_w  [2];
  logic [7:0]  dout_w  [2];

  wac_adc_capture u_a (
    .clk(clk), .nRst(nRst), .start(start_r[0]), .nFrames(nf_r[0]),
    .busy(busy_w[0]), .done(done_w[0]),
    .CSADC1(cs1[0]), .CSADC2(cs2[0]), .CLKADC1(ck1[0]), .CLKADC2(ck2[0]),
    .SDOADC1(sdo1[0]), .SDOADC2(sdo2[0]),
    .busBramAddr(addr_w[0]), .busBramOut(dout_w[0]), .ctrlWeBram(we_w[0])
  );

  wac_adc_capture #(.CLK_DIV(1), .QUIET(1)) u_b (
    .clk(clk), .nRst(nRst), .start(start_r[1]), .nFrames(nf_r[1]),
    .busy(busy_w[1]), .done(done_w[1]),
    .CSADC1(cs1[1]), .CSADC2(cs2[1]), .CLKADC1(ck1[1]), .CLKADC2(ck2[1]),
    .SDOADC1(sdo1[1]), .SDOADC2(sdo2[1]),
    .busBramAddr(addr_w[1]), .busBramOut(dout_w[1]), .ctrlWeBram(we_w[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  wr_t         q[$];
  logic [15:0] pat1 = 16'h0000;
  logic [15:0] pat2 = 16'h0000;
  logic        prev_cs [2];
  logic        prev_ck [2];
  logic        in_run  [2];
  int          hi_n    [2];
  int          lo_n    [2];
  int          rises   [2];
  int          we_cnt  [2];
  int          k0 = 0;
  int          pair_diff = 0;

  initial begin
    for (int i = 0; i < 2; i++) begin
      prev_cs[i] = 1'b1; prev_ck[i] = 1'b1; in_run[i] = 1'b0;
      hi_n[i] = 0; lo_n[i] = 0; rises[i] = 0; we_cnt[i] = 0;
    end
  end

  // Interface monitor plus serial ADC model for instance A (bit k presented after k rising SCLKs).
  always @(negedge clk) begin
    wr_t e;
    for (int i = 0; i < 2; i++) begin
      if (cs1[i] !== cs2[i] || ck1[i] !== ck2[i]) pair_diff++;
      if (!nRst) begin
        in_run[i] = 1'b0;
      end else begin
        if (cs1[i] && !prev_cs[i]) begin
          chk("sclk_rises_per_frame", rises[i], 16);
          chk("cs_low_len", lo_n[i], (i == 1) ? 33 : 66);
          hi_n[i]   = 1;
          in_run[i] = 1'b1;
        end else if (cs1[i]) begin
          hi_n[i]++;
        end else if (prev_cs[i]) begin
          if (in_run[i]) chk("cs_high_gap", hi_n[i], (i == 1) ? 5 : 8);
          lo_n[i]  = 1;
          rises[i] = 0;
        end else begin
          lo_n[i]++;
          if (ck1[i] && !prev_ck[i]) rises[i]++;
        end
        if (we_w[i]) begin
          we_cnt[i]++;
          if (q.size() == 0) begin
            chk("write_unexpected", 1, 0);
          end else begin
            e = q.pop_front();
            chk("wr_inst", i, int'(e.inst));
            chk("wr_addr", int'(addr_w[i]), int'(e.a));
            chk("wr_data", int'(dout_w[i]), int'(e.d));
          end
        end
        if (done_w[i]) in_run[i] = 1'b0;
      end
      if (i == 0) begin
        if (!nRst || cs1[0]) k0 = 0;
        else if (ck1[0] && !prev_ck[0]) k0++;
        sdo1[0] = (k0 < 16) ? pat1[15 - k0] : 1'b0;
        sdo2[0] = (k0 < 16) ? pat2[15 - k0] : 1'b0;
      end
      prev_cs[i] = cs1[i];
      prev_ck[i] = ck1[i];
    end
  end

  task automatic run(input int inst, input int nf, input logic [15:0] p1, input logic [15:0] p2,
                     input int flen, input int poke);
    int          nfe;
    int          cyc;
    logic        got;
    logic        pk_s;
    logic        pk_w;
    logic [11:0] c1;
    logic [11:0] c2;
    wr_t         e;
    nfe = (nf == 0) ? 1024 : nf;
    c1  = p1[11:0];
    c2  = p2[11:0];
    for (int f = 0; f < nfe; f++) begin
      e.inst = inst[0];
      e.a = 12'(4 * f + 0); e.d = c1[7:0];           q.push_back(e);
      e.a = 12'(4 * f + 1); e.d = {4'b0000, c1[11:8]}; q.push_back(e);
      e.a = 12'(4 * f + 2); e.d = c2[7:0];           q.push_back(e);
      e.a = 12'(4 * f + 3); e.d = {4'b0000, c2[11:8]}; q.push_back(e);
    end
    if (inst == 0) begin
      pat1 = p1;
      pat2 = p2;
    end
    nf_r[inst] = 10'(nf);
    @(negedge clk) start_r[inst] = 1'b1;
    @(negedge clk) start_r[inst] = 1'b0;
    chk("busy_after_start", int'(busy_w[inst]), 1);
    chk("cs_after_start", int'(cs1[inst]), 0);
    got = 1'b0; pk_s = 1'b0; pk_w = 1'b0;
    for (cyc = 1; cyc <= flen * nfe + 20; cyc++) begin
      @(negedge clk);
      start_r[inst] = 1'b0;
      if (done_w[inst]) begin
        got = 1'b1;
        break;
      end
      if (poke != 0 && !pk_s && !cs1[inst] && !ck1[inst]) begin
        start_r[inst] = 1'b1;
        nf_r[inst]    = 10'd5;
        pk_s          = 1'b1;
      end else if (poke != 0 && !pk_w && we_w[inst]) begin
        start_r[inst] = 1'b1;
        pk_w          = 1'b1;
      end
    end
    start_r[inst] = 1'b0;
    chk("done_seen", int'(got), 1);
    chk("run_cycles", cyc, flen * nfe);
    chk("busy_with_done", int'(busy_w[inst]), 0);
    @(negedge clk);
    chk("done_one_cycle", int'(done_w[inst]), 0);
    chk("busy_idle", int'(busy_w[inst]), 0);
    chk("addr_hold", int'(addr_w[inst]), (4 * nfe) % 4096);
    chk("sb_empty", q.size(), 0);
    if (!got) q.delete();
  endtask

  vec_t vecs[4];
  int   we_snap;
  int   wait_n;

  initial begin
    vecs[0] = '{inst: 0, nf: 1, p1: 16'hFFFF, p2: 16'h0000, flen: 74, poke: 0};
    vecs[1] = '{inst: 0, nf: 2, p1: 16'h0A5C, p2: 16'h0123, flen: 74, poke: 0};
    vecs[2] = '{inst: 0, nf: 2, p1: 16'h0A5C, p2: 16'h0123, flen: 74, poke: 1};
    vecs[3] = '{inst: 0, nf: 1, p1: 16'h0800, p2: 16'h07FF, flen: 74, poke: 0};

    nRst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_r[i] = 1'b0;
      nf_r[i]    = 10'd0;
    end
    sdo1[1] = 1'b1;
    sdo2[1] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs", int'(cs1[i]), 1);
      chk("rst_clk", int'(ck1[i]), 1);
      chk("rst_busy", int'(busy_w[i]), 0);
      chk("rst_done", int'(done_w[i]), 0);
      chk("rst_we", int'(we_w[i]), 0);
      chk("rst_addr", int'(addr_w[i]), 0);
      chk("rst_dout", int'(dout_w[i]), 0);
    end
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++)
      run(vecs[v].inst, vecs[v].nf, vecs[v].p1, vecs[v].p2, vecs[v].flen, vecs[v].poke);

    // Asynchronous reset in the middle of the first frame of a three-frame run.
    pat1 = 16'hFFFF;
    pat2 = 16'h0000;
    nf_r[0] = 10'd3;
    @(negedge clk) start_r[0] = 1'b1;
    @(negedge clk) start_r[0] = 1'b0;
    wait_n = 0;
    while (ck1[0] && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    repeat (5) @(negedge clk);
    chk("pre_rst_in_shift", int'(cs1[0]), 0);
    we_snap = we_cnt[0];
    #2 nRst = 1'b0;
    #1;
    chk("arst_cs1", int'(cs1[0]), 1);
    chk("arst_cs2", int'(cs2[0]), 1);
    chk("arst_clk1", int'(ck1[0]), 1);
    chk("arst_clk2", int'(ck2[0]), 1);
    chk("arst_busy", int'(busy_w[0]), 0);
    repeat (3) @(negedge clk);
    chk("arst_no_write", we_cnt[0], we_snap);
    chk("arst_addr", int'(addr_w[0]), 0);
    nRst = 1'b1;
    @(negedge clk);
    chk("arst_sb_empty", q.size(), 0);
    run(0, 1, 16'hFFFF, 16'h0000, 74, 0);

    run(1, 1, 16'hFFFF, 16'h0000, 38, 0);
    we_snap = we_cnt[1];
    run(1, 0, 16'hFFFF, 16'h0000, 38, 0);
    chk("full_run_writes", we_cnt[1] - we_snap, 4096);

    chk("cs_clk_pairs_equal", pair_diff, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wac_adc_capture.md
# wac_adc_capture

Dual serial-ADC acquisition engine for the WAC board. On a start pulse it runs a programmable number of simultaneous conversions on ADC1 and ADC2, which share chip-select timing and each have their own serial clock. It packs each pair of 12-bit results into four bytes and writes them sequentially into the 4 KB capture BRAM. The EPP side later reads that BRAM back to the host.

## Interface

Parameters:
- CLK_DIV, 2: clk cycles per half-period of CLKADCx (≥1).
- QUIET, 4: clk cycles CSADCx stays high between frames after the write burst (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- nRst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a capture run; ignored while busy.
- nFrames  in  10  conversion pairs per run, latched on start; 0 means 1024.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the run completes.
- CSADC1, CSADC2  out  1  ADC chip selects, active-low, driven identically.
- CLKADC1, CLKADC2  out  1  ADC serial clocks, driven identically, idle high.
- SDOADC1, SDOADC2  in  1  ADC serial data, MSB first.
- busBramAddr  out  12  BRAM byte address.
- busBramOut  out  8  BRAM write data.
- ctrlWeBram  out  1  BRAM write enable, one byte per high cycle.

## Operation

- States: IDLE, CSLOW, SHIFT, WRITE, QUIET, DONE.
- IDLE: on start, latch nFrames (0 → 1024), clear the address counter to 0, set busy, go to CSLOW.
- CSLOW: CSADCx low and CLKADCx high for CLK_DIV cycles, then go to SHIFT.
- SHIFT: 16 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
  - SDOADCx is sampled on the clk edge where CLKADCx goes high.
  - 16 bits are shifted in MSB first. The first 4 are discarded (leading zeros); the last 12 form chN[11:0].
  - After the 16th rising transition, go to WRITE.
- WRITE: CSADCx high, CLKADCx high. Four consecutive cycles with ctrlWeBram high write these bytes:
  - addr+0: ch1[7:0]
  - addr+1: {4'b0, ch1[11:8]}
  - addr+2: ch2[7:0]
  - addr+3: {4'b0, ch2[11:8]}
  - busBramAddr increments by 1 after each write and wraps modulo 4096.
- QUIET: CS high for QUIET cycles. Then decrement the frame count; if nonzero go to CSLOW, else go to DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, go to IDLE.
- start while not in IDLE has no effect. nFrames is only sampled on an accepted start.
- Reset (any time, including mid-frame) forces IDLE immediately and all outputs to their reset values. No partial frame is written.

## Timing

- Reset values: CSADCx=1, CLKADCx=1, busy=0, done=0, ctrlWeBram=0, busBramAddr=0, busBramOut=0.
- Start accepted at edge N: busy=1 and CSADCx=0 at edge N+1.
- Frame length = CLK_DIV + 32·CLK_DIV + 4 + QUIET clk cycles. With the defaults this is 74.
- busBramAddr and busBramOut are valid in the same cycle ctrlWeBram is high.
- done asserts QUIET+1 cycles after the last write cycle of the final frame.
- A run of 1024 frames writes addresses 0..4095 exactly once; busBramAddr then wraps to 0.
- Between runs, busBramAddr holds its last value; it is cleared only on an accepted start.

## Test plan

- Defaults, nFrames=1, SDOADC1=1 constant, SDOADC2=0 constant:
  - Exactly 16 CLKADC rising edges while CS is low.
  - Writes FF,0F,00,00 to addresses 0..3.
  - done arrives 74 cycles after busy rises; busy falls with done.
- nFrames=2, SDOADC1 driving pattern 0x0A5C and SDOADC2 driving 0x0123 MSB first:
  - Addresses 0..7 receive 5C,0A,23,01 twice.
  - CS is high for exactly 4+QUIET cycles between frames.
- nFrames=0: 1024 frames, 4096 writes, each address 0..4095 written once, busBramAddr back to 0, one done pulse.
- start pulsed mid-SHIFT and again during WRITE:
  - Both ignored; the write count stays 4·nFrames.
  - A new start after done runs again from address 0.
- nRst asserted during SHIFT of frame 1 of 3:
  - CS and CLK go high asynchronously; busy=0, no ctrlWeBram pulse.
  - After release, a fresh start with nFrames=1 behaves exactly as in the first scenario.
- CLK_DIV=1, QUIET=1: frame length 38 cycles; CLKADC toggles every clk; the data capture from the first scenario still holds.
